// File: rtl/spi_bus_pkg.sv
// rtl/spi_bus_pkg.sv - shared client indices, state encoding and defaults for the SPI bus sequencer
package spi_bus_pkg;

    localparam int CLI_GAIN = 0;
    localparam int CLI_ADC  = 1;
    localparam int CLI_DAC  = 2;

    localparam int TIMEOUT_DEF = 100;
    localparam int GAP_CYC_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_GAIN = 3'd1,
        ST_ADC  = 3'd2,
        ST_DAC  = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    function automatic logic [2:0] grant_of(state_e s);
        logic [2:0] g;
        g = '0;
        case (s)
            ST_GAIN: g[CLI_GAIN] = 1'b1;
            ST_ADC:  g[CLI_ADC]  = 1'b1;
            ST_DAC:  g[CLI_DAC]  = 1'b1;
            default: g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/spi_bus_mux.sv
// rtl/spi_bus_mux.sv - registered one-hot mux of client SCK/MOSI/CS onto the board SPI pins
module spi_bus_mux
    import spi_bus_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] grant,
    input  logic [2:0] cli_sck,
    input  logic [2:0] cli_mosi,
    input  logic [2:0] cli_cs_n,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       amp_cs,
    output logic       ad_conv,
    output logic       dac_cs
);

    logic sck_d, mosi_d, amp_cs_d, ad_conv_d, dac_cs_d;
    logic sck_q, mosi_q, amp_cs_q, ad_conv_q, dac_cs_q;

    // With no grant every select falls back to its inactive level.
    always_comb begin
        sck_d     = |(grant & cli_sck);
        mosi_d    = |(grant & cli_mosi);
        amp_cs_d  = grant[CLI_GAIN] ? cli_cs_n[CLI_GAIN]  : 1'b1;
        ad_conv_d = grant[CLI_ADC]  ? ~cli_cs_n[CLI_ADC]  : 1'b0;
        dac_cs_d  = grant[CLI_DAC]  ? cli_cs_n[CLI_DAC]   : 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sck_q     <= 1'b0;
            mosi_q    <= 1'b0;
            amp_cs_q  <= 1'b1;
            ad_conv_q <= 1'b0;
            dac_cs_q  <= 1'b1;
        end else begin
            sck_q     <= sck_d;
            mosi_q    <= mosi_d;
            amp_cs_q  <= amp_cs_d;
            ad_conv_q <= ad_conv_d;
            dac_cs_q  <= dac_cs_d;
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign amp_cs   = amp_cs_q;
    assign ad_conv  = ad_conv_q;
    assign dac_cs   = dac_cs_q;

endmodule

// File: rtl/spi_bus_sequencer.sv
// rtl/spi_bus_sequencer.sv - req/grant/done arbiter for the shared board SPI bus
module spi_bus_sequencer
    import spi_bus_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] req,
    input  logic [2:0] done,
    input  logic [2:0] cli_sck,
    input  logic [2:0] cli_mosi,
    input  logic [2:0] cli_cs_n,
    output logic [2:0] grant,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       amp_cs,
    output logic       ad_conv,
    output logic       dac_cs,
    output logic       spissb,
    output logic       sf_ce0,
    output logic       fpgainitb,
    output logic       timeout_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_e     state_q, state_d;
    logic       last_dac_q, last_dac_d;
    logic [7:0] wdog_q, wdog_d;
    logic [3:0] gap_q, gap_d;
    logic       tmo_q, tmo_d;
    logic [2:0] grant_q, grant_d;
    logic       done_hit;

    always_comb begin
        state_d    = state_q;
        last_dac_d = last_dac_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        tmo_d      = 1'b0;
        done_hit   = |(done & grant_q);
        case (state_q)
            ST_IDLE: begin
                wdog_d = '0;
                if (req[CLI_GAIN])                      state_d = ST_GAIN;
                else if (req[CLI_ADC] && req[CLI_DAC])  state_d = last_dac_q ? ST_ADC : ST_DAC;
                else if (req[CLI_ADC])                  state_d = ST_ADC;
                else if (req[CLI_DAC])                  state_d = ST_DAC;
            end
            ST_GAIN, ST_ADC, ST_DAC: begin
                if (wdog_q != 8'hFF) wdog_d = wdog_q + 8'd1;
                // A done on the expiry cycle wins, so no error is flagged then.
                if (done_hit || wdog_q >= TMO_LAST) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                    tmo_d   = !done_hit;
                    if (state_q == ST_ADC)      last_dac_d = 1'b0;
                    else if (state_q == ST_DAC) last_dac_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) state_d = ST_IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
        grant_d = grant_of(state_d);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            last_dac_q <= 1'b1;
            wdog_q     <= '0;
            gap_q      <= '0;
            tmo_q      <= 1'b0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_dac_q <= last_dac_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            grant_q    <= grant_d;
        end
    end

    spi_bus_mux u_mux (
        .clock    (clock),
        .resetn   (resetn),
        .grant    (grant_q),
        .cli_sck  (cli_sck),
        .cli_mosi (cli_mosi),
        .cli_cs_n (cli_cs_n),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .amp_cs   (amp_cs),
        .ad_conv  (ad_conv),
        .dac_cs   (dac_cs)
    );

    assign grant       = grant_q;
    assign timeout_err = tmo_q;
    assign spissb      = 1'b1;
    assign sf_ce0      = 1'b1;
    assign fpgainitb   = 1'b0;

endmodule
